// File: rtl/gaussian_pkg.sv
// gaussian_pkg: shared types and constants for the gaussian MMIO/CSR blocks.
//   - t_mmio_cmd            : host-side command to the MMIO initiator
//   - t_if_ccip_c0_Rx       : MMIO request channel (c0Rx subset, 64-bit data)
//   - t_if_ccip_c2_Tx       : MMIO read-response channel (c2Tx subset)
//   - CSR dword addresses shared with the CSR responder
package gaussian_pkg;

    localparam int          CCIP_MMIO_TID_W      = 9;
    localparam logic [1:0]  MMIO_LEN_32          = 2'b00;
    localparam logic [1:0]  MMIO_LEN_64          = 2'b01;
    localparam int          MMIO_TIMEOUT_DEFAULT = 1024;

    // CSR map, dword addresses (byte offset >> 2)
    localparam logic [15:0] CSR_DFH      = 16'h0000;
    localparam logic [15:0] CSR_AFU_ID_L = 16'h0002;
    localparam logic [15:0] CSR_AFU_ID_H = 16'h0004;
    localparam logic [15:0] CSR_DBG_CNT  = 16'h0006;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic        len64;
        logic [63:0] data;
    } t_mmio_cmd;

    typedef struct packed {
        logic [15:0]                address;
        logic [1:0]                 length;
        logic                       rsvd;
        logic [CCIP_MMIO_TID_W-1:0] tid;
    } t_ccip_c0_ReqMmioHdr;

    // MMIO payload never exceeds 64 bits, so the data field is trimmed.
    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [CCIP_MMIO_TID_W-1:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

endpackage

// File: rtl/gaussian_mmio_tid_fifo.sv
// gaussian_mmio_tid_fifo: in-order FIFO holding tids of in-flight MMIO reads.
//   clk, reset (async, active-low)
//   push/push_data : enqueue (caller guarantees !full or simultaneous pop)
//   pop            : dequeue head (caller guarantees !empty)
//   head           : oldest entry, valid when !empty
//   count/full/empty : occupancy
module gaussian_mmio_tid_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 9,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Explicit wrap keeps DEPTH == 1 legal with a 1-bit pointer.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/gaussian_mmio_initiator.sv
// gaussian_mmio_initiator: MMIO requester driving the CSR responder.
//   cmd_*          : read/write command in (valid/ready)
//   mmio_req       : registered c0Rx-format request, one cycle per command
//   mmio_rsp       : c2Tx-format read responses, matched in order by tid
//   rsp_*          : read completion pulse (data, tid, timeout flag)
//   stray_cnt      : saturating count of unmatched responses
//   rd_outstanding : in-flight read count
module gaussian_mmio_initiator
    import gaussian_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int TIMEOUT_CYCLES  = MMIO_TIMEOUT_DEFAULT,
    parameter  int TID_W           = CCIP_MMIO_TID_W,
    localparam int CW              = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [15:0]    cmd_addr,
    input  logic           cmd_len64,
    input  logic [63:0]    cmd_data,
    output t_if_ccip_c0_Rx mmio_req,
    input  t_if_ccip_c2_Tx mmio_rsp,
    output logic           rsp_valid,
    output logic [63:0]    rsp_data,
    output logic [TID_W-1:0] rsp_tid,
    output logic           rsp_timeout,
    output logic [15:0]    stray_cnt,
    output logic [CW-1:0]  rd_outstanding
);

    t_mmio_cmd        cmd;
    t_if_ccip_c0_Rx   req_d;
    logic             accept, push, pop, match, tmo_fire, stray;
    logic             full, empty;
    logic [TID_W-1:0] tid_cnt, head;
    logic [15:0]      tmo_cnt;

    assign cmd = '{write: cmd_write, addr: cmd_addr, len64: cmd_len64, data: cmd_data};

    // Responder completes in order, so only the head tid can match.
    assign match    = mmio_rsp.mmioRdValid && !empty && (mmio_rsp.hdr.tid == head);
    assign tmo_fire = !empty && !match && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign pop      = match || tmo_fire;
    assign stray    = mmio_rsp.mmioRdValid && !match;

    // A full tracker still takes a read when the head retires this cycle.
    assign cmd_ready = reset && !(!cmd_write && full && !pop);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && !cmd_write;

    gaussian_mmio_tid_fifo #(.DEPTH(MAX_OUTSTANDING), .W(TID_W)) u_tid_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (tid_cnt),
        .pop       (pop),
        .head      (head),
        .count     (rd_outstanding),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        req_d = '0;
        if (accept) begin
            req_d.mmioWrValid  = cmd.write;
            req_d.mmioRdValid  = !cmd.write;
            req_d.hdr.address  = cmd.addr;
            req_d.hdr.length   = cmd.len64 ? MMIO_LEN_64 : MMIO_LEN_32;
            req_d.hdr.tid      = cmd.write ? '0 : tid_cnt;
            req_d.data         = cmd.write ? cmd.data : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_req    <= '0;
            tid_cnt     <= '0;
            tmo_cnt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_tid     <= '0;
            rsp_timeout <= 1'b0;
            stray_cnt   <= '0;
        end else begin
            mmio_req  <= req_d;
            rsp_valid <= pop;
            if (push) tid_cnt <= tid_cnt + 1'b1;
            // Age of the current head; restarts whenever the head changes.
            if (empty || pop) tmo_cnt <= '0;
            else              tmo_cnt <= tmo_cnt + 1'b1;
            if (pop) begin
                rsp_data    <= match ? mmio_rsp.data : '0;
                rsp_tid     <= head;
                rsp_timeout <= tmo_fire;
            end
            if (stray && stray_cnt != 16'hFFFF) stray_cnt <= stray_cnt + 1'b1;
        end
    end

endmodule
